// File: rtl/altusoc_gpio_pkg.sv
// Shared register map and helpers for the AltuSOC Wishbone GPIO controller.
package altusoc_gpio_pkg;

  localparam int unsigned ADR_W = 4;

  localparam logic [ADR_W-1:0] REG_IN   = 4'h0;
  localparam logic [ADR_W-1:0] REG_OUT  = 4'h1;
  localparam logic [ADR_W-1:0] REG_OE   = 4'h2;
  localparam logic [ADR_W-1:0] REG_SET  = 4'h3;
  localparam logic [ADR_W-1:0] REG_CLR  = 4'h4;
  localparam logic [ADR_W-1:0] REG_IE   = 4'h5;
  localparam logic [ADR_W-1:0] REG_TYPE = 4'h6;
  localparam logic [ADR_W-1:0] REG_POL  = 4'h7;
  localparam logic [ADR_W-1:0] REG_STAT = 4'h8;

  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/altusoc_gpio_if.sv
// 32-bit Wishbone classic slave port bundle for the GPIO controller.
interface altusoc_gpio_if;
  logic [5:0]  adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [31:0] rdt;
  logic        ack;

  modport master (output adr, dat, sel, we, cyc, stb, input rdt, ack);
  modport slave  (input adr, dat, sel, we, cyc, stb, output rdt, ack);
endinterface

// File: rtl/altusoc_gpio_sync.sv
// Multi-stage synchroniser bringing asynchronous pad inputs into the clk domain.
module altusoc_gpio_sync #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] ff_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) ff_q[i] <= '0;
    end else begin
      ff_q[0] <= d;
      for (int i = 1; i < STAGES; i++) ff_q[i] <= ff_q[i-1];
    end
  end

  assign q = ff_q[STAGES-1];

endmodule

// File: rtl/altusoc_gpio.sv
// Wishbone GPIO controller: per-bit direction, atomic set/clear and edge/level interrupts.
module altusoc_gpio
  import altusoc_gpio_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  altusoc_gpio_if.slave     wb,
  input  logic [WIDTH-1:0]  i_gpio,
  output logic [WIDTH-1:0]  o_gpio,
  output logic [WIDTH-1:0]  o_gpio_oe,
  output logic              o_irq
);

  logic [WIDTH-1:0] gpio_in, hist_q;
  logic [WIDTH-1:0] out_q, out_d, oe_q, oe_d, ie_q, ie_d;
  logic [WIDTH-1:0] trig_q, trig_d, pol_q, pol_d, stat_q, stat_d;
  logic [WIDTH-1:0] edge_ev, level_ev, set_ev, w1c, wmask, wdat;
  logic [31:0]      wbits, rd, rdt_q, rdt_d;
  logic [ADR_W-1:0] reg_idx;
  logic             ack_q, irq_q, req, wr;
  logic             unused_bits;

  altusoc_gpio_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (i_gpio),
    .q     (gpio_in)
  );

  // A new request is only accepted while ack is low, so each strobe yields one ack pulse.
  assign req     = wb.cyc & wb.stb & ~ack_q;
  assign wr      = req & wb.we;
  assign reg_idx = wb.adr[5:2];
  assign wbits   = wb.dat & byte_mask(wb.sel);
  assign wmask   = byte_mask(wb.sel)[WIDTH-1:0];
  assign wdat    = wbits[WIDTH-1:0];
  assign unused_bits = ^{wb.adr[1:0], wbits};

  assign edge_ev  = (pol_q & gpio_in & ~hist_q) | (~pol_q & ~gpio_in & hist_q);
  assign level_ev = ~(gpio_in ^ pol_q);
  assign set_ev   = ie_q & ((trig_q & edge_ev) | (~trig_q & level_ev));

  always_comb begin
    out_d  = out_q;
    oe_d   = oe_q;
    ie_d   = ie_q;
    trig_d = trig_q;
    pol_d  = pol_q;
    w1c    = '0;
    if (wr) begin
      case (reg_idx)
        REG_OUT:  out_d  = (out_q & ~wmask) | wdat;
        REG_OE:   oe_d   = (oe_q & ~wmask) | wdat;
        REG_SET:  out_d  = out_q | wdat;
        REG_CLR:  out_d  = out_q & ~wdat;
        REG_IE:   ie_d   = (ie_q & ~wmask) | wdat;
        REG_TYPE: trig_d = (trig_q & ~wmask) | wdat;
        REG_POL:  pol_d  = (pol_q & ~wmask) | wdat;
        REG_STAT: w1c    = wdat;
        default:  ;
      endcase
    end
    // Clear is applied first so a coincident event keeps the bit pending.
    stat_d = (stat_q & ~w1c) | set_ev;
  end

  always_comb begin
    rd = '0;
    case (reg_idx)
      REG_IN:   rd[WIDTH-1:0] = gpio_in;
      REG_OUT:  rd[WIDTH-1:0] = out_q;
      REG_OE:   rd[WIDTH-1:0] = oe_q;
      REG_IE:   rd[WIDTH-1:0] = ie_q;
      REG_TYPE: rd[WIDTH-1:0] = trig_q;
      REG_POL:  rd[WIDTH-1:0] = pol_q;
      REG_STAT: rd[WIDTH-1:0] = stat_q;
      default:  rd = '0;
    endcase
    rdt_d = req ? rd : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      oe_q   <= '0;
      ie_q   <= '0;
      trig_q <= '0;
      pol_q  <= '0;
      stat_q <= '0;
      hist_q <= '0;
      ack_q  <= 1'b0;
      rdt_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      oe_q   <= oe_d;
      ie_q   <= ie_d;
      trig_q <= trig_d;
      pol_q  <= pol_d;
      stat_q <= stat_d;
      hist_q <= gpio_in;
      ack_q  <= req;
      rdt_q  <= rdt_d;
      irq_q  <= |stat_q;
    end
  end

  assign wb.ack    = ack_q;
  assign wb.rdt    = rdt_q;
  assign o_gpio    = out_q;
  assign o_gpio_oe = oe_q;
  assign o_irq     = irq_q;

endmodule
